// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage in-order pipeline: load-use stall, branch flush,
// EX operand forwarding and saturating performance counters.
module pipe_hazard_ctrl #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [ADDRESS_WIDTH-1:0] id_rs1,
   input  logic [ADDRESS_WIDTH-1:0] id_rs2,
   input  logic                     id_uses_rs1,
   input  logic                     id_uses_rs2,
   input  logic [ADDRESS_WIDTH-1:0] id_rd,
   input  logic                     id_regwrite,
   input  logic                     id_memread,
   input  logic                     ex_pcsrc,
   input  logic                     perf_clr,
   output logic                     stall_if,
   output logic                     stall_id,
   output logic                     flush_id,
   output logic                     flush_ex,
   output logic [1:0]               fwd_a,
   output logic [1:0]               fwd_b,
   output logic [CNT_WIDTH-1:0]     cycle_count,
   output logic [CNT_WIDTH-1:0]     retired_count,
   output logic [CNT_WIDTH-1:0]     stall_count,
   output logic [CNT_WIDTH-1:0]     flush_count
);

   typedef struct packed {
      logic                     valid;
      logic [ADDRESS_WIDTH-1:0] rd;
      logic                     regwrite;
      logic                     memread;
   } slot_t;

   slot_t                    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [ADDRESS_WIDTH-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic                     ex_uses_rs1_q, ex_uses_rs1_d;
   logic                     ex_uses_rs2_q, ex_uses_rs2_d;
   logic [CNT_WIDTH-1:0]     cycle_q, cycle_d, retired_q, retired_d;
   logic [CNT_WIDTH-1:0]     stall_q, stall_d, flush_q, flush_d;
   logic                     hazard, branch;

   function automatic logic [1:0] fwd_sel(input logic [ADDRESS_WIDTH-1:0] rs,
                                          input logic uses,
                                          input slot_t mem, input slot_t wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (uses && rs != '0) begin
         if (mem.valid && mem.regwrite && !mem.memread && mem.rd == rs)
            sel = 2'b10;
         else if (wb.valid && wb.regwrite && wb.rd == rs)
            sel = 2'b01;
      end
      return sel;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] cnt,
                                                 input logic inc);
      return (inc && cnt != '1) ? cnt + CNT_WIDTH'(1) : cnt;
   endfunction

   always_comb begin
      hazard = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
               ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                (id_uses_rs2 & (id_rs2 == ex_q.rd)));
      branch = ex_pcsrc & ex_q.valid;
   end

   // A taken branch wins over a load-use stall so the PC can take the target.
   assign stall_if = hazard & ~branch;
   assign stall_id = hazard & ~branch;
   assign flush_id = branch;
   assign flush_ex = branch;

   assign fwd_a = fwd_sel(ex_rs1_q, ex_uses_rs1_q, mem_q, wb_q);
   assign fwd_b = fwd_sel(ex_rs2_q, ex_uses_rs2_q, mem_q, wb_q);

   assign cycle_count   = cycle_q;
   assign retired_count = retired_q;
   assign stall_count   = stall_q;
   assign flush_count   = flush_q;

   always_comb begin
      mem_d          = ex_q;
      wb_d           = mem_q;
      ex_d.valid     = id_valid & ~hazard & ~branch;
      ex_d.rd        = id_rd;
      ex_d.regwrite  = id_regwrite;
      ex_d.memread   = id_memread;
      ex_rs1_d       = id_rs1;
      ex_rs2_d       = id_rs2;
      ex_uses_rs1_d  = id_uses_rs1;
      ex_uses_rs2_d  = id_uses_rs2;
      if (perf_clr) begin
         cycle_d   = '0;
         retired_d = '0;
         stall_d   = '0;
         flush_d   = '0;
      end else begin
         cycle_d   = bump(cycle_q, 1'b1);
         retired_d = bump(retired_q, wb_q.valid);
         stall_d   = bump(stall_q, stall_if);
         flush_d   = bump(flush_q, flush_ex);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_uses_rs1_q <= 1'b0;
         ex_uses_rs2_q <= 1'b0;
         cycle_q       <= '0;
         retired_q     <= '0;
         stall_q       <= '0;
         flush_q       <= '0;
      end else begin
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_uses_rs1_q <= ex_uses_rs1_d;
         ex_uses_rs2_q <= ex_uses_rs2_d;
         cycle_q       <= cycle_d;
         retired_q     <= retired_d;
         stall_q       <= stall_d;
         flush_q       <= flush_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios then random traffic,
// both checked against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
   logic       ex_pcsrc, perf_clr;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic        a_stall_if, a_stall_id, a_flush_id, a_flush_ex;
   logic [1:0]  a_fwd_a, a_fwd_b;
   logic [31:0] a_cyc, a_ret, a_stl, a_fls;
   logic        b_stall_if, b_stall_id, b_flush_id, b_flush_ex;
   logic [1:0]  b_fwd_a, b_fwd_b;
   logic [3:0]  b_cyc, b_ret, b_stl, b_fls;

   int tests = 0;
   int fails = 0;

   pipe_hazard_ctrl #(.ADDRESS_WIDTH(5), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_pcsrc(ex_pcsrc),
      .perf_clr(perf_clr), .stall_if(a_stall_if), .stall_id(a_stall_id),
      .flush_id(a_flush_id), .flush_ex(a_flush_ex), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
      .cycle_count(a_cyc), .retired_count(a_ret), .stall_count(a_stl), .flush_count(a_fls));

   pipe_hazard_ctrl #(.ADDRESS_WIDTH(5), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_pcsrc(ex_pcsrc),
      .perf_clr(perf_clr), .stall_if(b_stall_if), .stall_id(b_stall_id),
      .flush_id(b_flush_id), .flush_ex(b_flush_ex), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
      .cycle_count(b_cyc), .retired_count(b_ret), .stall_count(b_stl), .flush_count(b_fls));

   always #5 clk = ~clk;

   // Reference model: one record per in-flight instruction, indexed by stage.
   typedef struct packed {
      logic       v;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, rw, mr;
   } ins_t;

   ins_t   m_ex = '0, m_mem = '0, m_wb = '0;
   longint c32[4] = '{0, 0, 0, 0};
   longint c4[4]  = '{0, 0, 0, 0};

   function automatic logic m_hazard();
      return id_valid && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
             ((id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd));
   endfunction

   function automatic logic m_branch();
      return ex_pcsrc && m_ex.v;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic u);
      if (!u || r == 0) return 2'b00;
      if (m_mem.v && m_mem.rw && !m_mem.mr && m_mem.rd == r) return 2'b10;
      if (m_wb.v && m_wb.rw && m_wb.rd == r) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_update();
      logic   hz, br;
      longint inc[4];
      hz = m_hazard();
      br = m_branch();
      if (!rst) begin
         m_ex.v = 1'b0; m_mem.v = 1'b0; m_wb.v = 1'b0;
         for (int i = 0; i < 4; i++) begin c32[i] = 0; c4[i] = 0; end
      end else begin
         inc = '{1, longint'(m_wb.v), longint'(hz && !br), longint'(br)};
         for (int i = 0; i < 4; i++) begin
            c32[i] = perf_clr ? 0 : ((c32[i] + inc[i] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : c32[i] + inc[i]);
            c4[i]  = perf_clr ? 0 : ((c4[i] + inc[i] > 15) ? 15 : c4[i] + inc[i]);
         end
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = '{v: id_valid && !hz && !br, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                   u1: id_uses_rs1, u2: id_uses_rs2, rw: id_regwrite, mr: id_memread};
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      logic       st;
      logic [1:0] fa, fb;
      st = m_hazard() && !m_branch();
      fa = m_fwd(m_ex.rs1, m_ex.u1);
      fb = m_fwd(m_ex.rs2, m_ex.u2);
      chk("stall_if",  64'(a_stall_if), 64'(st));
      chk("stall_id",  64'(a_stall_id), 64'(st));
      chk("flush_id",  64'(a_flush_id), 64'(m_branch()));
      chk("flush_ex",  64'(a_flush_ex), 64'(m_branch()));
      chk("fwd_a",     64'(a_fwd_a), 64'(fa));
      chk("fwd_b",     64'(a_fwd_b), 64'(fb));
      chk("cycle32",   64'(a_cyc), 64'(c32[0]));
      chk("retired32", 64'(a_ret), 64'(c32[1]));
      chk("stall32",   64'(a_stl), 64'(c32[2]));
      chk("flush32",   64'(a_fls), 64'(c32[3]));
      chk("w4_ctrl",   64'({b_stall_if, b_stall_id, b_flush_id, b_flush_ex, b_fwd_a, b_fwd_b}),
                       64'({st, st, m_branch(), m_branch(), fa, fb}));
      chk("cycle4",    64'(b_cyc), 64'(c4[0]));
      chk("retired4",  64'(b_ret), 64'(c4[1]));
      chk("stall4",    64'(b_stl), 64'(c4[2]));
      chk("flush4",    64'(b_fls), 64'(c4[3]));
   endtask

   task automatic put(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic rw, input logic mr, input logic pc);
      id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw; id_memread = mr;
      ex_pcsrc = pc;
   endtask

   task automatic look();
      #1 cmp_all();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic nop();
      put(0, 0, 0, 0, 0, 0, 0, 0, 0);
      look();
      adv();
   endtask

   initial begin
      rst = 1'b0; perf_clr = 1'b0;
      put(1, 5, 5, 5, 1, 1, 1, 1, 1);
      adv();
      // second reset cycle, still with id_valid and ex_pcsrc high
      look();
      chk("rst_stall", 64'(a_stall_if | a_stall_id), 64'd0);
      chk("rst_flush", 64'(a_flush_id | a_flush_ex), 64'd0);
      chk("rst_fwd",   64'({a_fwd_a, a_fwd_b}), 64'd0);
      adv();
      rst = 1'b1;
      nop();
      look();
      chk("cyc_after_release", 64'(a_cyc), 64'd1);
      chk("ret_after_release", 64'(a_ret), 64'd0);

      // load x5, then add reading x5
      put(1, 5, 0, 0, 0, 0, 1, 1, 0); look(); adv();
      put(1, 6, 5, 0, 1, 0, 1, 0, 0); look();
      chk("lu_stall", 64'({a_stall_if, a_stall_id}), 64'b11);
      adv();
      put(1, 6, 5, 0, 1, 0, 1, 0, 0); look();
      chk("lu_stall_once", 64'(a_stall_if), 64'd0);
      adv();
      put(0, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("lu_fwd_wb", 64'(a_fwd_a), 64'b01);
      chk("lu_stall_cnt", 64'(a_stl), 64'd1);
      adv();

      // add x3; sub rs2=x3; or rs1=x3
      put(1, 3, 1, 2, 1, 1, 1, 0, 0); look(); adv();
      put(1, 4, 1, 3, 1, 1, 1, 0, 0); look(); adv();
      put(1, 8, 3, 1, 1, 1, 1, 0, 0); look();
      chk("alu_fwd_b_mem", 64'(a_fwd_b), 64'b10);
      adv();
      put(0, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("alu_fwd_a_wb", 64'(a_fwd_a), 64'b01);
      adv();

      // x0 never forwards or stalls
      put(1, 0, 1, 1, 1, 1, 1, 0, 0); look(); adv();
      put(1, 9, 0, 0, 1, 1, 1, 0, 0); look(); adv();
      put(1, 0, 1, 1, 0, 0, 1, 1, 0); look();
      chk("x0_fwd", 64'({a_fwd_a, a_fwd_b}), 64'd0);
      adv();
      put(1, 9, 0, 0, 1, 1, 1, 0, 0); look();
      chk("x0_no_stall", 64'(a_stall_if), 64'd0);
      adv();

      // x7 written twice, youngest producer in MEM wins
      put(1, 7, 1, 1, 0, 0, 1, 0, 0); look(); adv();
      put(1, 7, 1, 1, 0, 0, 1, 0, 0); look(); adv();
      put(1, 9, 7, 1, 1, 0, 1, 0, 0); look(); adv();
      put(0, 0, 0, 0, 0, 0, 0, 0, 0); look();
      chk("mem_priority", 64'(a_fwd_a), 64'b10);
      adv();
      nop(); nop(); nop();

      // taken branch with an instruction behind it
      put(1, 9, 1, 1, 0, 0, 1, 0, 0); look(); adv();
      put(1, 10, 1, 1, 0, 0, 1, 0, 1); look();
      chk("br_flush", 64'({a_flush_id, a_flush_ex}), 64'b11);
      adv();
      put(0, 0, 0, 0, 0, 0, 0, 0, 1); look();
      chk("br_bubble_ignored", 64'(a_flush_ex), 64'd0);
      adv();
      nop();
      look();
      chk("br_flush_cnt", 64'(a_fls), 64'd1);
      chk("sat4_cycle", 64'(b_cyc), 64'd15);
      nop(); nop();

      // branch in EX overrides a load-use hazard in ID
      put(1, 11, 1, 1, 0, 0, 1, 1, 0); look(); adv();
      put(1, 12, 11, 0, 1, 0, 1, 0, 1); look();
      chk("flush_over_stall", 64'({a_stall_if, a_stall_id, a_flush_ex}), 64'b001);
      adv();
      nop();

      perf_clr = 1'b1; nop(); perf_clr = 1'b0;
      look();
      chk("clr32", 64'({a_cyc, a_ret, a_stl, a_fls}) , 64'd0);
      chk("clr4",  64'({b_cyc, b_ret, b_stl, b_fls}), 64'd0);

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) != 0);
         perf_clr = ($urandom_range(0, 29) == 0);
         put(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0));
         look();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
